// File: rtl/wam_game_fsm.sv
// Whack-a-mole game-session controller: restart, ready countdown, play and game over.
// Scores keypad hits against the lit light and applies the points, timed and lives end rules.
module wam_game_fsm #(
  parameter int N_LIGHTS        = 9,
  parameter int SCORE_W         = 7,
  parameter int TICK_MAX        = 50_000_000,
  parameter int READY_SECS      = 5,
  parameter int TIME_SECS       = 60,
  parameter int LIVES           = 3,
  parameter int MAX_HITS_NORMAL = 25,
  parameter int MAX_HITS_EXT    = 50,
  localparam int IW             = (N_LIGHTS > 1) ? $clog2(N_LIGHTS) : 1
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic               ext,
  input  logic               light_new,
  input  logic               light_expire,
  input  logic [IW-1:0]      light_pos,
  input  logic               key_valid,
  input  logic [IW-1:0]      key_idx,
  output logic [2:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] misses,
  output logic [2:0]         lives_left,
  output logic [6:0]         time_left,
  output logic [3:0]         ready_left,
  output logic               flick_en,
  output logic               clear_n,
  output logic               hit,
  output logic               game_over
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READY   = 3'd1;
  localparam logic [2:0] S_PLAY    = 3'd2;
  localparam logic [2:0] S_OVER    = 3'd3;
  localparam logic [2:0] S_RESTART = 3'd4;
  localparam logic [1:0] M_TIMED   = 2'b01;
  localparam logic [1:0] M_LIVES   = 2'b10;
  localparam int DIV_W = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_MAX - 1);

  logic [2:0]         state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic               ext_q, ext_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [SCORE_W-1:0] score_q, score_d, misses_q, misses_d, done_q, done_d;
  logic [2:0]         lives_q, lives_d;
  logic [6:0]         time_q, time_d;
  logic [3:0]         ready_q, ready_d;
  logic               active_q, active_d, lock_q, lock_d, hit_q, hit_d;
  logic               tick, timed_mode, lives_mode, points_mode;
  logic               hit_ev, wrong_ev, miss_ev;
  logic [31:0]        max_hits;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + SCORE_W'(1);
  endfunction

  assign tick        = (div_q == DIV_LAST);
  assign timed_mode  = (mode_q == M_TIMED);
  assign lives_mode  = (mode_q == M_LIVES);
  assign points_mode = !timed_mode && !lives_mode;
  assign max_hits    = ext_q ? 32'(MAX_HITS_EXT) : 32'(MAX_HITS_NORMAL);

  // A hit wins over a same-cycle expiry; a wrong key and an expiry together cost one life.
  assign hit_ev   = key_valid && (key_idx == light_pos) && active_q && !lock_q;
  assign wrong_ev = key_valid && !hit_ev;
  assign miss_ev  = light_expire && !lock_q && !hit_ev;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    ext_d    = ext_q;
    div_d    = '0;
    score_d  = score_q;
    misses_d = misses_q;
    done_d   = done_q;
    lives_d  = lives_q;
    time_d   = time_q;
    ready_d  = ready_q;
    active_d = active_q;
    lock_d   = lock_q;
    hit_d    = 1'b0;
    if (start) begin
      state_d = S_RESTART;
    end else begin
      case (state_q)
        S_IDLE, S_OVER: ;
        S_RESTART: begin
          mode_d   = mode;
          ext_d    = ext;
          score_d  = '0;
          misses_d = '0;
          done_d   = '0;
          active_d = 1'b0;
          lock_d   = 1'b0;
          ready_d  = 4'(READY_SECS);
          lives_d  = 3'(LIVES);
          time_d   = 7'(TIME_SECS);
          state_d  = S_READY;
        end
        S_READY: begin
          div_d = tick ? '0 : div_q + DIV_W'(1);
          if (tick) begin
            ready_d = ready_q - 4'd1;
            if (ready_q == 4'd1) state_d = S_PLAY;
          end
        end
        S_PLAY: begin
          div_d = tick ? '0 : div_q + DIV_W'(1);
          if (hit_ev) begin
            score_d = sat_inc(score_q);
            done_d  = sat_inc(done_q);
            lock_d  = 1'b1;
            hit_d   = 1'b1;
          end else if (miss_ev) begin
            misses_d = sat_inc(misses_q);
            done_d   = sat_inc(done_q);
          end
          if (lives_mode && (wrong_ev || miss_ev) && lives_q != 3'd0) lives_d = lives_q - 3'd1;
          if (timed_mode && tick && time_q != 7'd0) time_d = time_q - 7'd1;
          if (light_expire) active_d = 1'b0;
          if (light_new) begin
            active_d = 1'b1;
            lock_d   = 1'b0;
          end
          if ((points_mode && 32'(done_d) == max_hits) ||
              (timed_mode && tick && time_q == 7'd1) ||
              (lives_mode && lives_d == 3'd0))
            state_d = S_OVER;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      mode_q   <= 2'b00;
      ext_q    <= 1'b0;
      div_q    <= '0;
      score_q  <= '0;
      misses_q <= '0;
      done_q   <= '0;
      lives_q  <= 3'd0;
      time_q   <= 7'd0;
      ready_q  <= 4'd0;
      active_q <= 1'b0;
      lock_q   <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      ext_q    <= ext_d;
      div_q    <= div_d;
      score_q  <= score_d;
      misses_q <= misses_d;
      done_q   <= done_d;
      lives_q  <= lives_d;
      time_q   <= time_d;
      ready_q  <= ready_d;
      active_q <= active_d;
      lock_q   <= lock_d;
      hit_q    <= hit_d;
    end
  end

  assign state      = state_q;
  assign score      = score_q;
  assign misses     = misses_q;
  assign lives_left = lives_q;
  assign time_left  = time_q;
  assign ready_left = ready_q;
  assign flick_en   = (state_q == S_PLAY);
  assign clear_n    = (state_q != S_RESTART);
  assign hit        = hit_q;
  assign game_over  = (state_q == S_OVER);
endmodule

// File: tb/tb_wam_game_fsm.sv
// Bench for wam_game_fsm: reset, ready countdown, timed/points/lives games, saturation, mid-game reset.
// A second instance with a 3-bit score shares the stimulus for the saturation case.
module tb_wam_game_fsm;
  localparam int IW = 4;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READY   = 3'd1;
  localparam logic [2:0] S_PLAY    = 3'd2;
  localparam logic [2:0] S_OVER    = 3'd3;
  localparam logic [2:0] S_RESTART = 3'd4;

  typedef struct packed {
    logic [2:0] st;
    logic [6:0] score;
    logic [6:0] misses;
    logic [2:0] lives;
    logic       hit;
  } exp_t;

  typedef struct packed {
    logic          lnew;
    logic          lexp;
    logic [IW-1:0] lpos;
    logic          kv;
    logic [IW-1:0] kidx;
    exp_t          e;
  } vec_t;

  logic          CLOCK_50 = 1'b0;
  logic          reset, start, ext, light_new, light_expire, key_valid;
  logic [1:0]    mode;
  logic [IW-1:0] light_pos, key_idx;
  logic [2:0]    state, lives_left, s_state, s_lives;
  logic [6:0]    score, misses, time_left, s_time;
  logic [3:0]    ready_left, s_ready;
  logic          flick_en, clear_n, hit, game_over;
  logic [2:0]    s_score, s_misses;
  logic          s_flick, s_clear_n, s_hit, s_over;

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  vec_t ltab[8];

  always #5 CLOCK_50 = ~CLOCK_50;

  wam_game_fsm #(.N_LIGHTS(9), .SCORE_W(7), .TICK_MAX(4), .READY_SECS(3), .TIME_SECS(3),
                 .LIVES(3), .MAX_HITS_NORMAL(25), .MAX_HITS_EXT(50)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .mode(mode), .ext(ext),
    .light_new(light_new), .light_expire(light_expire), .light_pos(light_pos),
    .key_valid(key_valid), .key_idx(key_idx), .state(state), .score(score), .misses(misses),
    .lives_left(lives_left), .time_left(time_left), .ready_left(ready_left),
    .flick_en(flick_en), .clear_n(clear_n), .hit(hit), .game_over(game_over));

  wam_game_fsm #(.N_LIGHTS(9), .SCORE_W(3), .TICK_MAX(4), .READY_SECS(3), .TIME_SECS(3),
                 .LIVES(3), .MAX_HITS_NORMAL(25), .MAX_HITS_EXT(50)) dut_s (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .mode(mode), .ext(ext),
    .light_new(light_new), .light_expire(light_expire), .light_pos(light_pos),
    .key_valid(key_valid), .key_idx(key_idx), .state(s_state), .score(s_score), .misses(s_misses),
    .lives_left(s_lives), .time_left(s_time), .ready_left(s_ready),
    .flick_en(s_flick), .clear_n(s_clear_n), .hit(s_hit), .game_over(s_over));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  function automatic vec_t mkv(input logic lnew, input logic lexp, input logic [IW-1:0] lpos,
                               input logic kv, input logic [IW-1:0] kidx, input logic [2:0] st,
                               input logic [6:0] sc, input logic [6:0] ms, input logic [2:0] lv,
                               input logic h);
    vec_t v;
    v.lnew = lnew; v.lexp = lexp; v.lpos = lpos; v.kv = kv; v.kidx = kidx;
    v.e.st = st; v.e.score = sc; v.e.misses = ms; v.e.lives = lv; v.e.hit = h;
    return v;
  endfunction

  // Drive one cycle of events, queue the expected result, compare it after the edge.
  task automatic apply(input string nm, input vec_t v);
    exp_t e;
    light_new = v.lnew; light_expire = v.lexp; light_pos = v.lpos;
    key_valid = v.kv;   key_idx = v.kidx;
    sbq.push_back(v.e);
    step();
    light_new = 1'b0; light_expire = 1'b0; key_valid = 1'b0;
    e = sbq.pop_front();
    check({nm, ".state"},  32'(state),      32'(e.st));
    check({nm, ".score"},  32'(score),      32'(e.score));
    check({nm, ".misses"}, 32'(misses),     32'(e.misses));
    check({nm, ".lives"},  32'(lives_left), 32'(e.lives));
    check({nm, ".hit"},    32'(hit),        32'(e.hit));
  endtask

  task automatic start_game(input logic [1:0] m, input logic x);
    mode = m; ext = x; start = 1'b1;
    step();
    start = 1'b0;
    check("sg_restart_state", 32'(state), 32'(S_RESTART));
    check("sg_clear_n", 32'(clear_n), 32'd0);
    step();
    check("sg_ready_state", 32'(state), 32'(S_READY));
    check("sg_score_clr", 32'(score), 32'd0);
    check("sg_misses_clr", 32'(misses), 32'd0);
    check("sg_lives_init", 32'(lives_left), 32'd3);
    check("sg_time_init", 32'(time_left), 32'd3);
    repeat (12) step();
    check("sg_play_state", 32'(state), 32'(S_PLAY));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    logic [IW-1:0] p;
    int ms, mm;
    ltab[0] = mkv(1'b1, 1'b0, 4'd2, 1'b0, 4'd0, S_PLAY, 7'd0, 7'd0, 3'd3, 1'b0);
    ltab[1] = mkv(1'b0, 1'b0, 4'd2, 1'b1, 4'd5, S_PLAY, 7'd0, 7'd0, 3'd2, 1'b0);
    ltab[2] = mkv(1'b0, 1'b1, 4'd2, 1'b0, 4'd0, S_PLAY, 7'd0, 7'd1, 3'd1, 1'b0);
    ltab[3] = mkv(1'b1, 1'b0, 4'd4, 1'b0, 4'd0, S_PLAY, 7'd0, 7'd1, 3'd1, 1'b0);
    ltab[4] = mkv(1'b0, 1'b1, 4'd4, 1'b1, 4'd4, S_PLAY, 7'd1, 7'd1, 3'd1, 1'b1);
    ltab[5] = mkv(1'b1, 1'b0, 4'd7, 1'b0, 4'd0, S_PLAY, 7'd1, 7'd1, 3'd1, 1'b0);
    ltab[6] = mkv(1'b0, 1'b1, 4'd7, 1'b1, 4'd0, S_OVER, 7'd1, 7'd2, 3'd0, 1'b0);
    ltab[7] = mkv(1'b0, 1'b0, 4'd7, 1'b1, 4'd3, S_OVER, 7'd1, 7'd2, 3'd0, 1'b0);

    reset = 1'b1; start = 1'b0; mode = 2'b01; ext = 1'b0;
    light_new = 1'b0; light_expire = 1'b0; light_pos = '0; key_valid = 1'b0; key_idx = '0;
    #1 reset = 1'b0;
    #2;
    check("rst_state", 32'(state), 32'(S_IDLE));
    check("rst_score", 32'(score), 32'd0);
    check("rst_lives", 32'(lives_left), 32'd0);
    check("rst_ready", 32'(ready_left), 32'd0);
    check("rst_clear_n", 32'(clear_n), 32'd1);
    check("rst_flick", 32'(flick_en), 32'd0);
    repeat (2) @(posedge CLOCK_50);
    #1 reset = 1'b1;
    step();
    check("idle_hold", 32'(state), 32'(S_IDLE));

    // Timed game: restart, 12-cycle ready countdown, 12-cycle play.
    start = 1'b1;
    step();
    start = 1'b0;
    check("rs_state", 32'(state), 32'(S_RESTART));
    check("rs_clear_n", 32'(clear_n), 32'd0);
    step();
    check("rdy_clear_n", 32'(clear_n), 32'd1);
    check("rdy_state0", 32'(state), 32'(S_READY));
    check("rdy_left0", 32'(ready_left), 32'd3);
    for (int i = 1; i < 12; i++) begin
      step();
      check("rdy_state", 32'(state), 32'(S_READY));
      check("rdy_left", 32'(ready_left), 32'(3 - i / 4));
    end
    step();
    check("play_entry", 32'(state), 32'(S_PLAY));
    check("play_ready0", 32'(ready_left), 32'd0);
    check("play_flick", 32'(flick_en), 32'd1);
    for (int j = 1; j <= 12; j++) begin
      step();
      if (j < 12) begin
        check("timed_state", 32'(state), 32'(S_PLAY));
        check("timed_left", 32'(time_left), 32'(3 - j / 4));
      end else begin
        check("timed_over", 32'(state), 32'(S_OVER));
        check("timed_left0", 32'(time_left), 32'd0);
        check("timed_flick", 32'(flick_en), 32'd0);
        check("timed_game_over", 32'(game_over), 32'd1);
      end
    end
    apply("over_ignore", mkv(1'b1, 1'b0, 4'd1, 1'b1, 4'd1, S_OVER, 7'd0, 7'd0, 3'd3, 1'b0));

    // Points game: 25 lights, first 10 hit, remaining 15 expire.
    start_game(2'b00, 1'b0);
    ms = 0; mm = 0;
    for (int k = 0; k < 25; k++) begin
      p = IW'(k % 9);
      apply("pts_new", mkv(1'b1, 1'b0, p, 1'b0, 4'd0, S_PLAY, 7'(ms), 7'(mm), 3'd3, 1'b0));
      if (k < 10) begin
        ms++;
        apply("pts_hit", mkv(1'b0, 1'b0, p, 1'b1, p, S_PLAY, 7'(ms), 7'(mm), 3'd3, 1'b1));
        if (k == 0) apply("pts_rekey", mkv(1'b0, 1'b0, p, 1'b1, p, S_PLAY, 7'(ms), 7'(mm), 3'd3, 1'b0));
        if (k == 1) apply("pts_lock_exp", mkv(1'b0, 1'b1, p, 1'b0, 4'd0, S_PLAY, 7'(ms), 7'(mm), 3'd3, 1'b0));
      end else begin
        mm++;
        apply("pts_exp", mkv(1'b0, 1'b1, p, 1'b0, 4'd0, (k == 24) ? S_OVER : S_PLAY,
                             7'(ms), 7'(mm), 3'd3, 1'b0));
      end
    end
    check("pts_flick_off", 32'(flick_en), 32'd0);

    // Lives game from OVER: counters restart cleared, then the table.
    start_game(2'b10, 1'b0);
    for (int t = 0; t < 8; t++) apply($sformatf("lives_vec%0d", t), ltab[t]);

    // Saturation on the 3-bit instance; mode change after restart must not matter.
    start_game(2'b10, 1'b0);
    mode = 2'b01;
    for (int i = 0; i < 9; i++) begin
      p = IW'(i % 9);
      apply("sat_new", mkv(1'b1, 1'b0, p, 1'b0, 4'd0, S_PLAY, 7'(i), 7'd0, 3'd3, 1'b0));
      apply("sat_hit", mkv(1'b0, 1'b0, p, 1'b1, p, S_PLAY, 7'(i + 1), 7'd0, 3'd3, 1'b1));
      check("sat_score_w3", 32'(s_score), (i + 1 > 7) ? 32'd7 : 32'(i + 1));
      check("sat_state_w3", 32'(s_state), 32'(S_PLAY));
    end

    // Asynchronous reset in the middle of play.
    reset = 1'b0;
    #2;
    check("mid_rst_state", 32'(state), 32'(S_IDLE));
    check("mid_rst_score", 32'(score), 32'd0);
    check("mid_rst_misses", 32'(misses), 32'd0);
    check("mid_rst_lives", 32'(lives_left), 32'd0);
    check("mid_rst_time", 32'(time_left), 32'd0);
    check("mid_rst_flick", 32'(flick_en), 32'd0);
    check("mid_rst_w3_state", 32'(s_state), 32'(S_IDLE));
    check("mid_rst_w3_score", 32'(s_score), 32'd0);
    check("mid_rst_w3_misses", 32'(s_misses), 32'd0);
    check("mid_rst_w3_lives", 32'(s_lives), 32'd0);
    check("mid_rst_w3_time", 32'(s_time), 32'd0);
    check("mid_rst_w3_ready", 32'(s_ready), 32'd0);
    check("mid_rst_w3_flick", 32'(s_flick), 32'd0);
    check("mid_rst_w3_clear_n", 32'(s_clear_n), 32'd1);
    check("mid_rst_w3_hit", 32'(s_hit), 32'd0);
    check("mid_rst_w3_over", 32'(s_over), 32'd0);
    #2 reset = 1'b1;
    step();
    check("post_rst_idle", 32'(state), 32'(S_IDLE));
    check("post_rst_game_over", 32'(game_over), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
